// File: rtl/geometry_sequencer.sv
// Frame controller for the geometry pipeline. It fetches one quad of vertices and waits out
// the pipeline latency. It then hands the screen-space quad to the rasterizer over valid/ready.
module geometry_sequencer #(
  parameter int ADDR_W   = 12,
  parameter int PIPE_LAT = 3,
  parameter int CNT_W    = 10
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [CNT_W-1:0]        quad_count,
  input  logic [15:0][15:0]       vm_in,
  output logic                    mem_rd,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [15:0]             mem_rdata,
  output logic [15:0][15:0]       vm,
  output logic [3:0][2:0][15:0]   gp_vertices,
  input  logic [3:0][1:0][9:0]    gp_ss,
  output logic                    quad_valid,
  input  logic                    quad_ready,
  output logic [3:0][1:0][9:0]    quad_ss,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, OUT, FIN} state_t;

  localparam int WAIT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(PIPE_LAT - 1);

  state_t                  state_q, state_d;
  logic                    mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [15:0][15:0]       vm_q, vm_d;
  logic [3:0][2:0][15:0]   gp_vtx_q, gp_vtx_d;
  logic                    quad_valid_q, quad_valid_d;
  logic [3:0][1:0][9:0]    quad_ss_q, quad_ss_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [CNT_W-1:0]        quad_count_q, quad_count_d;
  logic [CNT_W-1:0]        q_idx_q, q_idx_d;
  logic [3:0]              fetch_cnt_q, fetch_cnt_d;
  logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;

  always_comb begin
    state_d      = state_q;
    mem_rd_d     = mem_rd_q;
    mem_addr_d   = mem_addr_q;
    vm_d         = vm_q;
    gp_vtx_d     = gp_vtx_q;
    quad_valid_d = quad_valid_q;
    quad_ss_d    = quad_ss_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    quad_count_d = quad_count_q;
    q_idx_d      = q_idx_q;
    fetch_cnt_d  = fetch_cnt_q;
    wait_cnt_d   = wait_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          vm_d         = vm_in;
          quad_count_d = quad_count;
          q_idx_d      = '0;
          busy_d       = 1'b1;
          if (quad_count == '0) begin
            state_d = FIN;
          end else begin
            state_d     = FETCH;
            mem_rd_d    = 1'b1;
            mem_addr_d  = base_addr;
            fetch_cnt_d = '0;
          end
        end
      end

      FETCH: begin
        fetch_cnt_d = fetch_cnt_q + 4'd1;
        // The address register stops on the last word, so the next quad starts at mem_addr + 1.
        if (fetch_cnt_q < 4'd11) begin
          mem_rd_d   = 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
        end else begin
          mem_rd_d = 1'b0;
        end
        for (int k = 0; k < 12; k++) begin
          if (fetch_cnt_q == 4'(k + 1)) gp_vtx_d[k / 3][k % 3] = mem_rdata;
        end
        if (fetch_cnt_q == 4'd12) begin
          state_d    = WAIT;
          wait_cnt_d = '0;
        end
      end

      WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (wait_cnt_q == WAIT_LAST) begin
          quad_ss_d    = gp_ss;
          quad_valid_d = 1'b1;
          state_d      = OUT;
        end
      end

      OUT: begin
        if (quad_ready) begin
          quad_valid_d = 1'b0;
          if ((CNT_W + 1)'(q_idx_q) + 1'b1 < (CNT_W + 1)'(quad_count_q)) begin
            q_idx_d     = q_idx_q + 1'b1;
            state_d     = FETCH;
            mem_rd_d    = 1'b1;
            mem_addr_d  = mem_addr_q + 1'b1;
            fetch_cnt_d = '0;
          end else begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      FIN: begin
        // An empty frame arrives with busy still set; it spends one more cycle here to pulse done.
        done_d  = busy_q;
        busy_d  = 1'b0;
        state_d = busy_q ? FIN : IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      vm_q         <= '0;
      gp_vtx_q     <= '0;
      quad_valid_q <= 1'b0;
      quad_ss_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      quad_count_q <= '0;
      q_idx_q      <= '0;
      fetch_cnt_q  <= '0;
      wait_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      vm_q         <= vm_d;
      gp_vtx_q     <= gp_vtx_d;
      quad_valid_q <= quad_valid_d;
      quad_ss_q    <= quad_ss_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      quad_count_q <= quad_count_d;
      q_idx_q      <= q_idx_d;
      fetch_cnt_q  <= fetch_cnt_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign vm          = vm_q;
  assign gp_vertices = gp_vtx_q;
  assign quad_valid  = quad_valid_q;
  assign quad_ss     = quad_ss_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_geometry_sequencer.sv
// Directed bench for geometry_sequencer with a scoreboard of expected addresses and quads.
// It also models the vertex memory and a simple combinational stand-in for the geometry pipeline.
module tb_geometry_sequencer;

  typedef logic [3:0][1:0][9:0] quad_t;

  logic                  Clk = 1'b0;
  logic                  Reset_n;
  logic                  start;
  logic [11:0]           base_addr;
  logic [9:0]            quad_count;
  logic [15:0][15:0]     vm_in;
  logic                  mem_rd;
  logic [11:0]           mem_addr;
  logic [15:0]           mem_rdata = 16'h0;
  logic [15:0][15:0]     vm;
  logic [3:0][2:0][15:0] gp_vertices;
  quad_t                 gp_ss;
  logic                  quad_valid;
  logic                  quad_ready;
  quad_t                 quad_ss;
  logic                  busy;
  logic                  done;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  logic [11:0]       exp_addr[$];
  quad_t             exp_quad[$];
  logic [15:0][15:0] exp_vm;

  geometry_sequencer #(.ADDR_W(12), .PIPE_LAT(3), .CNT_W(10)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .base_addr(base_addr),
    .quad_count(quad_count), .vm_in(vm_in), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .vm(vm), .gp_vertices(gp_vertices), .gp_ss(gp_ss),
    .quad_valid(quad_valid), .quad_ready(quad_ready), .quad_ss(quad_ss),
    .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] mem_val(input logic [11:0] a);
    return 16'({4'b0, a} * 16'h9E37) ^ 16'hA5C3;
  endfunction

  // Pipeline stand-in: x' = x ^ z, y' = y + z, truncated to 10 bits.
  function automatic quad_t xform(input logic [3:0][2:0][15:0] v);
    quad_t r;
    for (int i = 0; i < 4; i++) begin
      r[i][0] = 10'(v[i][0] ^ v[i][2]);
      r[i][1] = 10'(v[i][1] + v[i][2]);
    end
    return r;
  endfunction

  function automatic quad_t quad_at(input logic [11:0] a);
    logic [3:0][2:0][15:0] v;
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 3; c++) v[i][c] = mem_val(a + 12'(3 * i + c));
    return xform(v);
  endfunction

  always @(posedge Clk) mem_rdata <= mem_val(mem_addr);
  always_comb gp_ss = xform(gp_vertices);

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge Clk) begin
    if (Reset_n === 1'b1) begin
      if (mem_rd) begin
        rd_cnt++;
        if (exp_addr.size() == 0) chk("mem_rd_unexpected", 1'b1, 1'b0);
        else chk("mem_addr", mem_addr, exp_addr.pop_front());
      end
      if (quad_valid && quad_ready) begin
        xfer_cnt++;
        if (exp_quad.size() == 0) chk("xfer_unexpected", 1'b1, 1'b0);
        else chk("quad_ss", quad_ss, exp_quad.pop_front());
      end
      if (done) done_cnt++;
      if (busy) chk("vm_hold", vm, exp_vm);
      chk("busy_and_done", busy & done, 1'b0);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_frame(input logic [11:0] b, input logic [9:0] n);
    logic [15:0][15:0] m;
    for (int i = 0; i < 16; i++) m[i] = 16'($urandom);
    vm_in = m;
    exp_vm = m;
    base_addr = b;
    quad_count = n;
    for (int q = 0; q < int'(n); q++) begin
      for (int k = 0; k < 12; k++) exp_addr.push_back(b + 12'(12 * q + k));
      exp_quad.push_back(quad_at(b + 12'(12 * q)));
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    logic found;
    found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("done_timeout", found, 1'b1);
    tick();
  endtask

  initial begin
    int r0, d0, x0;
    logic found;
    quad_t snap;

    Reset_n = 1'b0; start = 1'b0; quad_ready = 1'b1;
    base_addr = '0; quad_count = '0; vm_in = '0; exp_vm = '0;
    tick_n(2);
    chk("rst_ctrl", {mem_rd, quad_valid, busy, done}, 4'b0);
    chk("rst_addr", mem_addr, 12'h0);
    chk("rst_vm", vm, 256'h0);
    chk("rst_gp", gp_vertices, 192'h0);
    chk("rst_quad_ss", quad_ss, 80'h0);
    Reset_n = 1'b1;
    tick();

    // Single quad, ready tied high; cycle 0 is the one that presents start.
    r0 = rd_cnt; d0 = done_cnt;
    start_frame(12'h010, 10'd1);
    chk("sq_busy_c1", busy, 1'b1);
    chk("sq_rd_c1", {mem_rd, mem_addr}, {1'b1, 12'h010});
    tick_n(11);
    chk("sq_rd_c12", {mem_rd, mem_addr}, {1'b1, 12'h01B});
    tick();
    chk("sq_rd_c13", mem_rd, 1'b0);
    tick();
    chk("sq_gp_v32", gp_vertices[3][2], mem_val(12'h01B));
    tick_n(2);
    chk("sq_valid_c16", quad_valid, 1'b0);
    tick();
    chk("sq_valid_c17", quad_valid, 1'b1);
    tick();
    chk("sq_c18", {quad_valid, done, busy}, 3'b010);
    tick();
    chk("sq_done_c19", done, 1'b0);
    chk("sq_rd_count", rd_cnt - r0, 12);
    chk("sq_done_count", done_cnt - d0, 1);

    // Reset while word 5 of the first quad is being issued.
    start_frame(12'h100, 10'd3);
    tick_n(5);
    chk("rst_mid_word5", {mem_rd, mem_addr}, {1'b1, 12'h105});
    d0 = done_cnt;
    Reset_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", {mem_rd, quad_valid, busy, done}, 4'b0);
    chk("rst_mid_addr", mem_addr, 12'h0);
    chk("rst_mid_vm_gp", {vm, gp_vertices}, 448'h0);
    exp_addr.delete();
    exp_quad.delete();
    tick_n(2);
    Reset_n = 1'b1;
    r0 = rd_cnt;
    tick_n(5);
    chk("rst_mid_no_rd", rd_cnt - r0, 0);
    chk("rst_mid_no_done", done_cnt - d0, 0);
    chk("rst_mid_idle", busy, 1'b0);

    // Backpressure: hold ready low for five cycles of quad_valid.
    quad_ready = 1'b0;
    x0 = xfer_cnt; d0 = done_cnt;
    start_frame(12'h200, 10'd2);
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (quad_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("bp_valid_timeout", found, 1'b1);
    snap = quad_ss;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", quad_valid, 1'b1);
      chk("bp_ss_stable", quad_ss, snap);
      chk("bp_no_fetch", mem_rd, 1'b0);
      tick();
    end
    quad_ready = 1'b1;
    tick();
    chk("bp_next_fetch", {quad_valid, mem_rd, mem_addr}, {1'b0, 1'b1, 12'h20C});
    wait_done(100);
    chk("bp_xfers", xfer_cnt - x0, 2);
    chk("bp_done", done_cnt - d0, 1);

    // Address wrap at the top of vertex memory.
    r0 = rd_cnt;
    start_frame(12'hFFA, 10'd1);
    wait_done(100);
    chk("wrap_rd_count", rd_cnt - r0, 12);
    chk("wrap_sb_empty", exp_addr.size(), 0);

    // Empty frame.
    r0 = rd_cnt; d0 = done_cnt;
    start_frame(12'h300, 10'd0);
    chk("zero_c1", {busy, done, mem_rd}, 3'b100);
    tick();
    chk("zero_c2", {busy, done}, 2'b01);
    tick();
    chk("zero_c3", done, 1'b0);
    chk("zero_no_rd", rd_cnt - r0, 0);
    chk("zero_done_count", done_cnt - d0, 1);

    // Three quads with vm_in churning every cycle and stray start pulses mid-frame.
    r0 = rd_cnt; x0 = xfer_cnt; d0 = done_cnt;
    start_frame(12'h400, 10'd3);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      for (int j = 0; j < 16; j++) vm_in[j] = 16'($urandom);
      start = (i == 4 || i == 30);
      base_addr = 12'h800;
      quad_count = 10'd5;
      if (done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    start = 1'b0;
    chk("vm_frame_timeout", found, 1'b1);
    tick();
    chk("vm_frame_rd", rd_cnt - r0, 36);
    chk("vm_frame_xfers", xfer_cnt - x0, 3);
    chk("vm_frame_done", done_cnt - d0, 1);

    chk("sb_addr_empty", exp_addr.size(), 0);
    chk("sb_quad_empty", exp_quad.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
